snoop_bus_sequencer: RTL and testbench
======================================

# snoop_bus_sequencer

Sequences coherence transactions on the shared two-core snooping bus. It arbitrates between the core 1 and core 2 cache controllers with round-robin priority and holds a one-hot grant for the whole transaction. It forwards the winner's operation and address to the other core's snoop port, waits for that core's snoop acknowledge, and returns hit and data to the requester. It sits between the two L1 cache controllers and replaces the purely combinational bus crossbar for multi-cycle transactions.

## Interface
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT, 16, maximum SNOOP cycles before forced completion (used only with the timeout feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req1 / req2  in  1  transaction request from core 1 / core 2 (level)
- op1 / op2  in  2  requested op: BusRd=2'b00, BusUpgr=2'b01, BusRdX=2'b10, BusNoN=2'b11
- addr1 / addr2  in  ADDR_W  requested address
- grant1 / grant2  out  1  registered; at most one is high
- snoop_valid1 / snoop_valid2  out  1  snoop request to core 1 / core 2
- snoop_op1 / snoop_op2  out  2  forwarded op (BusNoN when idle)
- snoop_addr1 / snoop_addr2  out  ADDR_W  forwarded address
- snoop_ack1 / snoop_ack2  in  1  snooping core has completed its lookup
- snoop_hit1 / snoop_hit2  in  1  snooping core holds the line (qualified by ack)
- snoop_data1 / snoop_data2  in  DATA_W  line data (qualified by ack and hit)
- resp_valid1 / resp_valid2  out  1  one-cycle completion pulse to the requester
- resp_hit1 / resp_hit2  out  1  latched snoop hit
- resp_data1 / resp_data2  out  DATA_W  latched snoop data; 0 on miss
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, SNOOP and RESP.
- IDLE: a request is eligible when req is high and op is not BusNoN. BusNoN requests are ignored and receive no grant.
  - One eligible requester: grant it.
  - Two eligible requesters: grant the core not served last. The last-served pointer resets to core 2, so core 1 wins the first tie.
  - On a grant, latch the winner id, op and addr, update the last-served pointer, and go to SNOOP.
- SNOOP:
  - Drive snoop_valid, snoop_op and snoop_addr to the non-winning core only. The other core's snoop outputs stay idle (valid 0, op BusNoN, addr 0).
  - On the edge where that core's snoop_ack is high, latch hit, and latch data if hit else 0. Go to RESP.
  - Acks from the winning core are ignored.
- RESP: pulse resp_valid, with resp_hit and resp_data, to the winner for exactly one cycle. Drop the grant and go to IDLE.
- BusUpgr follows the same sequence. The requester ignores resp_data; the sequencer still latches it.
- Grant, op and addr are frozen from grant to RESP. Requester changes to req, op or addr mid-transaction are ignored, and the transaction always completes.
- resp_hit and resp_data hold their last values until the next RESP. resp_valid alone qualifies them.
- Reset, including reset mid-transaction, forces IDLE and the following output values:
  - all grant, snoop_valid and resp_valid outputs 0
  - snoop_op BusNoN, snoop_addr 0
  - resp_hit 0, resp_data 0, busy 0
  - last-served pointer = core 2

## Timing
- Request visible in cycle 0 (IDLE) gives grant and snoop_valid in cycle 1.
- Ack high in cycle 1 gives resp_valid in cycle 2, then IDLE in cycle 3.
- Minimum latency is 2 cycles from request to resp_valid. Each ack wait cycle adds 1.
- A pending request seen in IDLE in cycle 3 is granted in cycle 4. Sustained throughput is one transaction per 3 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- BUS_SEQ_TIMEOUT_EN defined:
  - A SNOOP-cycle counter, cleared on entry to SNOOP, forces RESP with hit 0 and data 0 when it reaches TIMEOUT without an ack.
  - An extra output, timeout_err (out, 1, reset 0), pulses together with that resp_valid.
  - An ack arriving in the same cycle the counter hits TIMEOUT wins.
- Not defined: SNOOP waits indefinitely, with no counter and no timeout_err port.

## Structure
- Shared package bus_pkg holds:
  - bus_op_t (BUS_RD, BUS_UPGR, BUS_RDX, BUS_NON)
  - seq_state_t (IDLE, SNOOP, RESP)
  - core_id_t
- Sub-module bus_rr_pick is the combinational two-way round-robin selector. Inputs are the two eligible bits and the last-served id; outputs are the grant-valid bit and the winner id.

## Test plan
- Core 1 only: req1=1, op1=BusRd, addr1=0x100; core 2 acks in the first SNOOP cycle with hit=1, data=0xDEADBEEF. Expect:
  - grant1 in cycle 1
  - snoop_addr2=0x100 and snoop_op2=BusRd in cycle 1
  - resp_valid1=1, resp_hit1=1, resp_data1=0xDEADBEEF in cycle 2
- Simultaneous req1 and req2 (BusRdX) held high for 12 cycles. Expect grants in the order core1, core2, core1, core2, each lasting two cycles, and never both grants high.
- req2 with op2=BusNoN. Expect no grant and busy=0 for 10 cycles.
- Core 2 BusUpgr where core 1 delays its ack by 5 cycles with hit=0. Expect:
  - snoop_valid1 held for 6 cycles
  - resp_valid2 in cycle 7, with resp_hit2=0 and resp_data2=0
- Reset asserted in SNOOP. Expect all outputs at their reset values on the next edge, and core 1 winning the next tie.
- BUS_SEQ_TIMEOUT_EN defined, TIMEOUT=4, no ack. Expect resp_valid1 and timeout_err pulsed together after 4 SNOOP cycles, with resp_hit1=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the two-core snooping bus sequencer: bus ops, FSM states, core ids.
package bus_pkg;
  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {IDLE, SNOOP, RESP} seq_state_t;

  typedef enum logic {CORE1 = 1'b0, CORE2 = 1'b1} core_id_t;
endpackage

// File: rtl/bus_rr_pick.sv
// Combinational two-way round-robin selector; on a tie the core not served last wins.
module bus_rr_pick
  import bus_pkg::*;
(
  input  logic     elig1,
  input  logic     elig2,
  input  core_id_t last,
  output logic     gnt_vld,
  output core_id_t win
);
  always_comb begin
    gnt_vld = elig1 | elig2;
    win     = CORE1;
    if (elig1 && elig2) win = (last == CORE1) ? CORE2 : CORE1;
    else if (elig2)     win = CORE2;
  end
endmodule

// File: rtl/snoop_bus_sequencer.sv
// Two-core snoop bus sequencer: round-robin grant, snoop the other core, return hit/data.
// Optional BUS_SEQ_TIMEOUT_EN adds a SNOOP-cycle timeout with a timeout_err pulse.
module snoop_bus_sequencer
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef BUS_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req1,
  input  logic              req2,
  input  logic [1:0]        op1,
  input  logic [1:0]        op2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic              grant1,
  output logic              grant2,
  output logic              snoop_valid1,
  output logic              snoop_valid2,
  output logic [1:0]        snoop_op1,
  output logic [1:0]        snoop_op2,
  output logic [ADDR_W-1:0] snoop_addr1,
  output logic [ADDR_W-1:0] snoop_addr2,
  input  logic              snoop_ack1,
  input  logic              snoop_ack2,
  input  logic              snoop_hit1,
  input  logic              snoop_hit2,
  input  logic [DATA_W-1:0] snoop_data1,
  input  logic [DATA_W-1:0] snoop_data2,
  output logic              resp_valid1,
  output logic              resp_valid2,
  output logic              resp_hit1,
  output logic              resp_hit2,
  output logic [DATA_W-1:0] resp_data1,
  output logic [DATA_W-1:0] resp_data2,
  output logic              busy
`ifdef BUS_SEQ_TIMEOUT_EN
  , output logic            timeout_err
`endif
);
  seq_state_t        state;
  core_id_t          win_id, last, pick;
  logic              gnt_vld;
  logic              s_ack, s_hit, done, d_hit;
  logic [DATA_W-1:0] s_data, d_data;

  bus_rr_pick u_pick (
    .elig1   (req1 && (op1 != BUS_NON)),
    .elig2   (req2 && (op2 != BUS_NON)),
    .last    (last),
    .gnt_vld (gnt_vld),
    .win     (pick)
  );

`ifdef BUS_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             d_to;
`endif

  // Only the non-winning core's snoop response completes the transaction.
  always_comb begin
    s_ack  = (win_id == CORE1) ? snoop_ack2  : snoop_ack1;
    s_hit  = (win_id == CORE1) ? snoop_hit2  : snoop_hit1;
    s_data = (win_id == CORE1) ? snoop_data2 : snoop_data1;
    done   = s_ack;
    d_hit  = s_hit;
    d_data = s_hit ? s_data : '0;
`ifdef BUS_SEQ_TIMEOUT_EN
    d_to   = 1'b0;
    if (!s_ack && cnt == CNT_W'(TIMEOUT - 1)) begin
      done   = 1'b1;
      d_hit  = 1'b0;
      d_data = '0;
      d_to   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      win_id       <= CORE1;
      last         <= CORE2;
      grant1       <= 1'b0;
      grant2       <= 1'b0;
      snoop_valid1 <= 1'b0;
      snoop_valid2 <= 1'b0;
      snoop_op1    <= BUS_NON;
      snoop_op2    <= BUS_NON;
      snoop_addr1  <= '0;
      snoop_addr2  <= '0;
      resp_valid1  <= 1'b0;
      resp_valid2  <= 1'b0;
      resp_hit1    <= 1'b0;
      resp_hit2    <= 1'b0;
      resp_data1   <= '0;
      resp_data2   <= '0;
      busy         <= 1'b0;
`ifdef BUS_SEQ_TIMEOUT_EN
      cnt          <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          state  <= SNOOP;
          win_id <= pick;
          last   <= pick;
          busy   <= 1'b1;
          grant1 <= (pick == CORE1);
          grant2 <= (pick == CORE2);
`ifdef BUS_SEQ_TIMEOUT_EN
          cnt    <= '0;
`endif
          if (pick == CORE1) begin
            snoop_valid2 <= 1'b1;
            snoop_op2    <= op1;
            snoop_addr2  <= addr1;
          end else begin
            snoop_valid1 <= 1'b1;
            snoop_op1    <= op2;
            snoop_addr1  <= addr2;
          end
        end
        SNOOP: if (done) begin
          state        <= RESP;
          snoop_valid1 <= 1'b0;
          snoop_valid2 <= 1'b0;
          snoop_op1    <= BUS_NON;
          snoop_op2    <= BUS_NON;
          snoop_addr1  <= '0;
          snoop_addr2  <= '0;
`ifdef BUS_SEQ_TIMEOUT_EN
          timeout_err  <= d_to;
`endif
          if (win_id == CORE1) begin
            resp_valid1 <= 1'b1;
            resp_hit1   <= d_hit;
            resp_data1  <= d_data;
          end else begin
            resp_valid2 <= 1'b1;
            resp_hit2   <= d_hit;
            resp_data2  <= d_data;
          end
        end
`ifdef BUS_SEQ_TIMEOUT_EN
        else cnt <= cnt + 1'b1;
`endif
        RESP: begin
          state       <= IDLE;
          resp_valid1 <= 1'b0;
          resp_valid2 <= 1'b0;
          grant1      <= 1'b0;
          grant2      <= 1'b0;
          busy        <= 1'b0;
`ifdef BUS_SEQ_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snoop_bus_sequencer.sv
// Scoreboard bench for snoop_bus_sequencer: directed transactions, monitor pops on resp_valid.
module tb_snoop_bus_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        req1, req2;
  logic [1:0]  op1, op2;
  logic [31:0] addr1, addr2;
  logic        grant1, grant2, snoop_valid1, snoop_valid2;
  logic [1:0]  snoop_op1, snoop_op2;
  logic [31:0] snoop_addr1, snoop_addr2;
  logic        snoop_ack1, snoop_ack2, snoop_hit1, snoop_hit2;
  logic [31:0] snoop_data1, snoop_data2;
  logic        resp_valid1, resp_valid2, resp_hit1, resp_hit2;
  logic [31:0] resp_data1, resp_data2;
  logic        busy;
`ifdef BUS_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

`ifdef BUS_SEQ_TIMEOUT_EN
  snoop_bus_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
`else
  snoop_bus_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
`endif
    .clk(clk), .reset(reset),
    .req1(req1), .req2(req2), .op1(op1), .op2(op2), .addr1(addr1), .addr2(addr2),
    .grant1(grant1), .grant2(grant2),
    .snoop_valid1(snoop_valid1), .snoop_valid2(snoop_valid2),
    .snoop_op1(snoop_op1), .snoop_op2(snoop_op2),
    .snoop_addr1(snoop_addr1), .snoop_addr2(snoop_addr2),
    .snoop_ack1(snoop_ack1), .snoop_ack2(snoop_ack2),
    .snoop_hit1(snoop_hit1), .snoop_hit2(snoop_hit2),
    .snoop_data1(snoop_data1), .snoop_data2(snoop_data2),
    .resp_valid1(resp_valid1), .resp_valid2(resp_valid2),
    .resp_hit1(resp_hit1), .resp_hit2(resp_hit2),
    .resp_data1(resp_data1), .resp_data2(resp_data2),
    .busy(busy)
`ifdef BUS_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  typedef struct {
    int          core;
    logic        hit;
    logic [31:0] data;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int core, input logic hit, input logic [31:0] data, input logic to);
    exp_t e;
    e.core = core; e.hit = hit; e.data = data; e.to = to;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic quiet();
    req1 = 0; req2 = 0; op1 = 2'b11; op2 = 2'b11; addr1 = 0; addr2 = 0;
    snoop_ack1 = 0; snoop_ack2 = 0; snoop_hit1 = 0; snoop_hit2 = 0;
    snoop_data1 = 0; snoop_data2 = 0;
  endtask

  // Monitor: every response pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (!reset) begin
      chk("grant_excl", {31'b0, grant1 & grant2}, 32'd0);
      if (resp_valid1 || resp_valid2) begin
        if (sb.size() == 0) chk("resp_unexpected", {30'b0, resp_valid2, resp_valid1}, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("resp_core", (resp_valid1 && !resp_valid2) ? 32'd1 :
                           (resp_valid2 && !resp_valid1) ? 32'd2 : 32'd3, mon_e.core);
          chk("resp_hit", {31'b0, resp_valid1 ? resp_hit1 : resp_hit2}, {31'b0, mon_e.hit});
          chk("resp_data", resp_valid1 ? resp_data1 : resp_data2, mon_e.data);
`ifdef BUS_SEQ_TIMEOUT_EN
          chk("timeout_err", {31'b0, timeout_err}, {31'b0, mon_e.to});
`endif
        end
      end
    end
  end

  logic [11:0] g1_tab, g2_tab;

  initial begin
    quiet();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    mid();
    chk("rst_grant", {30'b0, grant2, grant1}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_svalid", {30'b0, snoop_valid2, snoop_valid1}, 32'd0);
    chk("rst_sop", {28'b0, snoop_op2, snoop_op1}, 32'hF);
    next_cycle();
    reset = 0;

    // Tie with BusRdX held 12 cycles: core1, core2, core1, core2.
    g1_tab = 12'h186;
    g2_tab = 12'hC30;
    next_cycle();
    req1 = 1; req2 = 1; op1 = 2'b10; op2 = 2'b10; addr1 = 32'h200; addr2 = 32'h300;
    snoop_ack1 = 1; snoop_ack2 = 1; snoop_hit1 = 1; snoop_hit2 = 1;
    snoop_data1 = 32'h1111_1111; snoop_data2 = 32'h2222_2222;
    push(1, 1, 32'h2222_2222, 0);
    push(2, 1, 32'h1111_1111, 0);
    push(1, 1, 32'h2222_2222, 0);
    push(2, 1, 32'h1111_1111, 0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      mid();
      chk($sformatf("tie_grant1_c%0d", c), {31'b0, grant1}, {31'b0, g1_tab[c]});
      chk($sformatf("tie_grant2_c%0d", c), {31'b0, grant2}, {31'b0, g2_tab[c]});
    end
    next_cycle();
    quiet();
    mid();
    chk("tie_end_grant", {30'b0, grant2, grant1}, 32'd0);
    repeat (2) next_cycle();

    // Core 1 BusRd, core 2 acks in first SNOOP cycle with a hit.
    next_cycle();
    req1 = 1; op1 = 2'b00; addr1 = 32'h100;
    snoop_ack2 = 1; snoop_hit2 = 1; snoop_data2 = 32'hDEAD_BEEF;
    push(1, 1, 32'hDEAD_BEEF, 0);
    next_cycle();
    req1 = 0;
    mid();
    chk("rd_grant1", {30'b0, grant2, grant1}, 32'd1);
    chk("rd_saddr2", snoop_addr2, 32'h100);
    chk("rd_sop2", {30'b0, snoop_op2}, 32'd0);
    chk("rd_svalid", {30'b0, snoop_valid2, snoop_valid1}, 32'd2);
    chk("rd_sop1_idle", {30'b0, snoop_op1}, 32'd3);
    next_cycle();
    mid();
    chk("rd_resp_valid1", {31'b0, resp_valid1}, 32'd1);
    next_cycle();
    quiet();
    next_cycle();

    // BusNoN request is never granted.
    next_cycle();
    req2 = 1; op2 = 2'b11; addr2 = 32'h999;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      mid();
      chk($sformatf("non_grant_c%0d", c), {30'b0, grant2, grant1}, 32'd0);
      chk($sformatf("non_busy_c%0d", c), {31'b0, busy}, 32'd0);
    end

    // Core 2 BusUpgr; core 1 acks 5 cycles late with a miss, core 2's own ack ignored.
    next_cycle();
    req2 = 1; op2 = 2'b01; addr2 = 32'h400;
    snoop_ack2 = 1; snoop_hit2 = 1; snoop_data2 = 32'h55;
    snoop_ack1 = 0; snoop_hit1 = 0; snoop_data1 = 32'hCAFE_F00D;
    push(2, 0, 32'h0, 0);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if (c == 1) req2 = 0;
      if (c == 6) snoop_ack1 = 1;
      if (c == 7) snoop_ack1 = 0;
      mid();
      if (c <= 6) begin
        chk($sformatf("upg_svalid1_c%0d", c), {30'b0, snoop_valid2, snoop_valid1}, 32'd1);
        chk($sformatf("upg_sop1_c%0d", c), {30'b0, snoop_op1}, 32'd1);
        chk($sformatf("upg_saddr1_c%0d", c), snoop_addr1, 32'h400);
        chk($sformatf("upg_nresp_c%0d", c), {31'b0, resp_valid2}, 32'd0);
      end else begin
        chk("upg_svalid1_drop", {31'b0, snoop_valid1}, 32'd0);
        chk("upg_resp_valid2", {31'b0, resp_valid2}, 32'd1);
        chk("upg_resp_data2", resp_data2, 32'd0);
      end
    end
    next_cycle();
    quiet();
    next_cycle();

    // Reset during SNOOP, then core 1 wins the next tie.
    next_cycle();
    req1 = 1; op1 = 2'b00; addr1 = 32'h500;
    next_cycle();
    req1 = 0;
    mid();
    chk("rs_grant1", {31'b0, grant1}, 32'd1);
    chk("rs_busy", {31'b0, busy}, 32'd1);
    next_cycle();
    reset = 1;
    next_cycle();
    mid();
    chk("rs_grant", {30'b0, grant2, grant1}, 32'd0);
    chk("rs_svalid", {30'b0, snoop_valid2, snoop_valid1}, 32'd0);
    chk("rs_sop", {28'b0, snoop_op2, snoop_op1}, 32'hF);
    chk("rs_saddr2", snoop_addr2, 32'd0);
    chk("rs_rvalid", {30'b0, resp_valid2, resp_valid1}, 32'd0);
    chk("rs_rhit", {30'b0, resp_hit2, resp_hit1}, 32'd0);
    chk("rs_rdata1", resp_data1, 32'd0);
    chk("rs_busy0", {31'b0, busy}, 32'd0);
    next_cycle();
    reset = 0;
    req1 = 1; req2 = 1; op1 = 2'b00; op2 = 2'b00; addr1 = 32'h600; addr2 = 32'h700;
    snoop_ack1 = 1; snoop_ack2 = 1; snoop_hit1 = 1; snoop_hit2 = 1;
    snoop_data1 = 32'hA1; snoop_data2 = 32'hB2;
    push(1, 1, 32'hB2, 0);
    next_cycle();
    req1 = 0; req2 = 0;
    mid();
    chk("rs_tie_grant", {30'b0, grant2, grant1}, 32'd1);
    chk("rs_tie_saddr2", snoop_addr2, 32'h600);
    repeat (2) next_cycle();
    quiet();
    next_cycle();

`ifdef BUS_SEQ_TIMEOUT_EN
    // No ack: forced completion after 4 SNOOP cycles.
    next_cycle();
    req1 = 1; op1 = 2'b00; addr1 = 32'h800;
    push(1, 0, 32'h0, 1);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 1) req1 = 0;
      mid();
      if (c <= 4) chk($sformatf("to_wait_c%0d", c), {30'b0, resp_valid1, busy}, 32'd1);
      else begin
        chk("to_resp_valid1", {31'b0, resp_valid1}, 32'd1);
        chk("to_err", {31'b0, timeout_err}, 32'd1);
        chk("to_hit", {31'b0, resp_hit1}, 32'd0);
      end
    end
    repeat (2) next_cycle();
`endif

    repeat (3) next_cycle();
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
